// File: rtl/iram_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iram_param_pkg
// Description : Shared definitions for the instruction RAM block: the
//               controller state encoding and the default fill word used
//               for cleared or unloaded entries.
// Revision    : 1.0 - initial release
// ============================================================================
package iram_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

endpackage : iram_param_pkg
`default_nettype wire

// File: rtl/iram_store.sv
`default_nettype none
// ============================================================================
// Module      : iram_store
// Description : Storage array for the instruction RAM. One synchronous
//               write port and one combinational read port.
// Ports       : clk    - write clock
//               we     - write enable
//               waddr  - write entry index
//               wdata  - write word
//               raddr  - read entry index
//               rdata  - read word (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module iram_store #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // No reset on the array: the controller clears it after every reset.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : iram_store
`default_nettype wire

// File: rtl/iram_param.sv
`default_nettype none
// ============================================================================
// Module      : iram_param
// Description : Parameterised instruction RAM with a clear-then-load
//               program reload sequencer and a combinational fetch port.
// Ports       : CLK        - clock, all state on posedge
//               RESET      - synchronous active-low reset
//               ADDR       - fetch byte address (word index = ADDR[MSB:1])
//               Q          - fetched word, NOP_WORD while BUSY
//               ALIGN_ERR  - ADDR[0]
//               BUSY       - high while clearing or loading
//               LOAD_START - request a program reload (honoured in IDLE)
//               LD_VALID / LD_DATA / LD_LAST / LD_READY - load beat stream
//               LOAD_DONE  - one-cycle pulse at load completion
//               LD_COUNT   - words written by the last load
// Revision    : 1.0 - initial release
// ============================================================================
module iram_param
    import iram_param_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Q,
    output logic              ALIGN_ERR,
    output logic              BUSY,
    input  logic              LOAD_START,
    input  logic              LD_VALID,
    input  logic [DATA_W-1:0] LD_DATA,
    input  logic              LD_LAST,
    output logic              LD_READY,
    output logic              LOAD_DONE,
    output logic [ADDR_W-1:0] LD_COUNT
);

    localparam int PTR_W = ADDR_W - 1;
    localparam int DEPTH = 2 ** PTR_W;

    localparam logic [PTR_W-1:0]  LAST_CLR  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_WPTR = ADDR_W'(DEPTH - 1);

    state_t              state;
    state_t              next_state;
    logic [PTR_W-1:0]    clr_ptr;
    // One bit wider than an entry index so the beat total can reach DEPTH.
    logic [ADDR_W-1:0]   wptr;
    logic                pending;
    logic [ADDR_W-1:0]   load_count;

    logic                mem_we;
    logic [PTR_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                accept;
    logic                load_end;

    assign LD_READY  = (state == ST_LOAD);
    assign BUSY      = (state == ST_CLEAR) || (state == ST_LOAD);
    assign LOAD_DONE = (state == ST_DONE);
    assign LD_COUNT  = load_count;
    assign ALIGN_ERR = ADDR[0];
    assign Q         = BUSY ? NOP_WORD : mem_rdata;

    assign accept   = LD_VALID && LD_READY;
    // The DEPTH bound ends the load so the pointer never wraps to entry 0.
    assign load_end = accept && (LD_LAST || (wptr == LAST_WPTR));

    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        mem_waddr  = clr_ptr;
        mem_wdata  = NOP_WORD;
        case (state)
            ST_IDLE: begin
                if (LOAD_START) begin
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (clr_ptr == LAST_CLR) begin
                    next_state = pending ? ST_LOAD : ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    mem_we    = 1'b1;
                    mem_waddr = wptr[PTR_W-1:0];
                    mem_wdata = LD_DATA;
                end
                if (load_end) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= ST_CLEAR;
            clr_ptr    <= '0;
            wptr       <= '0;
            pending    <= 1'b0;
            load_count <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (LOAD_START) begin
                        pending <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // Wraps back to 0 on the final entry, ready for the next clear.
                    clr_ptr <= clr_ptr + 1'b1;
                    wptr    <= '0;
                end
                ST_LOAD: begin
                    if (accept) begin
                        wptr <= wptr + 1'b1;
                    end
                    if (load_end) begin
                        load_count <= wptr + 1'b1;
                    end
                end
                ST_DONE: begin
                    pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    iram_store #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_store (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (ADDR[ADDR_W-1:1]),
        .rdata (mem_rdata)
    );

endmodule : iram_param
`default_nettype wire

// File: tb/tb_iram_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_iram_param
// Description : Directed self-checking bench for iram_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iram_param;

    logic        CLK;
    logic        RESET;
    logic [7:0]  ADDR;
    logic [15:0] Q;
    logic        ALIGN_ERR;
    logic        BUSY;
    logic        LOAD_START;
    logic        LD_VALID;
    logic [15:0] LD_DATA;
    logic        LD_LAST;
    logic        LD_READY;
    logic        LOAD_DONE;
    logic [7:0]  LD_COUNT;

    int          tests    = 0;
    int          fails    = 0;
    int          done_cnt = 0;
    logic [15:0] exp_mem [128];

    iram_param #(
        .DATA_W   (16),
        .ADDR_W   (8),
        .NOP_WORD (16'h0000)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ADDR       (ADDR),
        .Q          (Q),
        .ALIGN_ERR  (ALIGN_ERR),
        .BUSY       (BUSY),
        .LOAD_START (LOAD_START),
        .LD_VALID   (LD_VALID),
        .LD_DATA    (LD_DATA),
        .LD_LAST    (LD_LAST),
        .LD_READY   (LD_READY),
        .LOAD_DONE  (LOAD_DONE),
        .LD_COUNT   (LD_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (LOAD_DONE === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 128; i++) exp_mem[i] = 16'h0000;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (BUSY && n < 400) begin
            tick();
            n++;
        end
        check_eq(tag, n, 128);
    endtask

    task automatic start_load(input string tag);
        int n;
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
        clear_model();
        n = 0;
        while (!LD_READY && n < 400) begin
            tick();
            n++;
        end
        check_eq(tag, n, 128);
    endtask

    task automatic verify_mem(input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < 128; i++) begin
            ADDR = 8'(i * 2);
            #1;
            if (Q !== exp_mem[i]) errs++;
        end
        check_eq(tag, errs, 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int k;
        int acc;
        logic ready_after;

        RESET      = 1'b0;
        ADDR       = 8'h00;
        LOAD_START = 1'b0;
        LD_VALID   = 1'b0;
        LD_DATA    = 16'h0000;
        LD_LAST    = 1'b0;
        clear_model();

        // Reset held for three cycles
        repeat (3) tick();
        check_eq("rst_busy", BUSY, 1);
        check_eq("rst_ready", LD_READY, 0);
        check_eq("rst_done", LOAD_DONE, 0);
        check_eq("rst_count", LD_COUNT, 0);
        check_eq("rst_q_nop", Q, 16'h0000);
        RESET = 1'b1;
        wait_idle("post_rst_clear_len");
        verify_mem("post_rst_all_nop");

        // 42-beat load, LOAD_START asserted mid-load must do nothing
        start_load("load42_clear_len");
        for (int i = 0; i < 42; i++) begin
            LD_VALID   = 1'b1;
            LD_DATA    = 16'(i);
            LD_LAST    = (i == 41);
            LOAD_START = (i == 5);
            exp_mem[i] = 16'(i);
            tick();
        end
        LD_VALID = 1'b0; LD_LAST = 1'b0; LOAD_START = 1'b0;
        check_eq("load42_done_pulse", LOAD_DONE, 1);
        check_eq("load42_count", LD_COUNT, 42);
        check_eq("load42_ready_low", LD_READY, 0);
        tick();
        check_eq("load42_done_one_cycle", LOAD_DONE, 0);
        check_eq("load42_idle", BUSY, 0);
        ADDR = 8'h52; #1;
        check_eq("q_52", Q, 16'h0029);
        ADDR = 8'h54; #1;
        check_eq("q_54", Q, 16'h0000);
        ADDR = 8'h05; #1;
        check_eq("align_err_05", ALIGN_ERR, 1);
        check_eq("q_05", Q, 16'h0002);
        ADDR = 8'h04; #1;
        check_eq("align_err_04", ALIGN_ERR, 0);
        tick(); tick();
        check_eq("no_reload_from_load_start", BUSY, 0);
        check_eq("load42_pulse_count", done_cnt, 1);
        verify_mem("load42_contents");

        // Valid toggled every other cycle; invalid cycles carry junk and LD_LAST
        start_load("toggle_clear_len");
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                LD_VALID   = 1'b1;
                LD_DATA    = 16'(k);
                LD_LAST    = (k == 9);
                exp_mem[k] = 16'(k);
                k++;
            end else begin
                LD_VALID = 1'b0;
                LD_DATA  = 16'hDEAD;
                LD_LAST  = 1'b1;
            end
            tick();
        end
        LD_VALID = 1'b0; LD_LAST = 1'b0;
        check_eq("toggle_count", LD_COUNT, 10);
        check_eq("toggle_idle", BUSY, 0);
        check_eq("toggle_pulse_count", done_cnt, 2);
        verify_mem("toggle_contents");

        // 130 beats, no LD_LAST: the depth bound ends the load after 128
        start_load("full_clear_len");
        acc = 0;
        ready_after = 1'b1;
        for (int i = 0; i < 130; i++) begin
            LD_VALID = 1'b1;
            LD_DATA  = 16'h8000 + 16'(i);
            LD_LAST  = 1'b0;
            if (LD_READY) begin
                acc++;
                if (acc <= 128) exp_mem[acc-1] = LD_DATA;
            end
            tick();
            if (i == 127) ready_after = LD_READY;
        end
        LD_VALID = 1'b0;
        check_eq("full_accepted", acc, 128);
        check_eq("full_ready_drop", ready_after, 0);
        check_eq("full_count", LD_COUNT, 128);
        check_eq("full_pulse_count", done_cnt, 3);
        ADDR = 8'h00; #1;
        check_eq("full_mem0_kept", Q, 16'h8000);
        verify_mem("full_contents");

        // Reset during a load aborts it
        start_load("abort_clear_len");
        for (int i = 0; i < 10; i++) begin
            LD_VALID = 1'b1;
            LD_DATA  = 16'hBEEF;
            tick();
        end
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        LD_VALID = 1'b0;
        check_eq("abort_busy", BUSY, 1);
        check_eq("abort_ready", LD_READY, 0);
        clear_model();
        wait_idle("abort_reclear_len");
        check_eq("abort_no_pulse", done_cnt, 3);
        check_eq("abort_count_reset", LD_COUNT, 0);
        check_eq("abort_stays_idle", LD_READY, 0);
        verify_mem("abort_all_nop");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_iram_param
`default_nettype wire

// File: doc/iram_param.md
IRAM_PARAM -- requirements
Module: iram_param

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 16, instruction word width in bits
- ADDR_W, 8, byte-address width; DEPTH = 2**(ADDR_W-1) halfword-aligned entries
- NOP_WORD, 16'h0000, fill value for cleared and unloaded entries
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK, input, 1, single clock; all state on posedge
- RESET, input, 1, synchronous, active-low reset
- ADDR, input, ADDR_W, fetch byte address; word index = ADDR[ADDR_W-1:1]
- Q, output, DATA_W, fetched instruction word
- ALIGN_ERR, output, 1, high when ADDR[0]=1 (combinational)
- BUSY, output, 1, high while clearing or loading
- LOAD_START, input, 1, request a program reload
- LD_VALID, input, 1, load beat valid
- LD_DATA, input, DATA_W, load beat word
- LD_LAST, input, 1, final beat marker
- LD_READY, output, 1, block accepts load beats
- LOAD_DONE, output, 1, one-cycle pulse at load completion
- LD_COUNT, output, ADDR_W, number of words written by the last load

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, LOAD, DONE.
REQ-004 Fetch read SHALL be combinational: Q = mem[ADDR[ADDR_W-1:1]] when BUSY=0, and Q = NOP_WORD when BUSY=1.
REQ-005 ALIGN_ERR SHALL equal ADDR[0] in every state; Q ignores ADDR[0].
REQ-006 CLEAR SHALL write NOP_WORD to one entry per cycle, pointer 0..DEPTH-1, taking exactly DEPTH cycles.
REQ-007 CLEAR exit: go to LOAD if a load is pending, otherwise go to IDLE.
REQ-008 In IDLE, LOAD_START=1 SHALL set the load-pending flag and enter CLEAR next cycle.
REQ-009 LOAD_START SHALL be ignored in CLEAR, LOAD and DONE.
REQ-010 In LOAD, LD_READY SHALL be 1; it SHALL be 0 in all other states.
REQ-011 A beat is accepted when LD_VALID && LD_READY; on acceptance, mem[wptr] <= LD_DATA and wptr increments.
REQ-012 LOAD SHALL exit to DONE on an accepted beat with LD_LAST=1, or on the accepted beat at wptr = DEPTH-1, whichever comes first.
REQ-013 On a DEPTH-bound exit, LD_READY SHALL drop the following cycle; no wrap to entry 0 is allowed.
REQ-014 In DONE, LOAD_DONE SHALL be 1 for exactly one cycle, LD_COUNT SHALL hold the accepted-beat total, the pending flag SHALL clear, and the next state SHALL be IDLE.
REQ-015 Entries not written during a load SHALL read NOP_WORD.
REQ-016 LD_VALID with LD_READY=0 SHALL cause no write; LD_LAST without LD_VALID SHALL be ignored.
REQ-017 LD_COUNT width SHALL be ADDR_W, so a full load of DEPTH (128) words is representable.
REQ-018 A full-depth load SHALL report LD_COUNT = DEPTH.

Reset
REQ-019 While RESET=0 at a posedge: state <= CLEAR, clear pointer <= 0, wptr <= 0, pending <= 0, LD_COUNT <= 0, LOAD_DONE <= 0.
REQ-020 During and after reset, BUSY=1 and LD_READY=0 until the post-reset CLEAR completes, after DEPTH cycles with RESET=1.
REQ-021 Reset asserted mid-LOAD SHALL abort the load, discard pending, restart CLEAR, and produce no LOAD_DONE pulse.

Structure
REQ-022 A shared package SHALL hold the FSM state enum and the default NOP_WORD constant.
REQ-023 The storage array SHALL be one sub-module, iram_store: one synchronous write port and one combinational read port, parametrised by DATA_W and DEPTH.
REQ-024 The FSM, pointers and handshake logic SHALL reside in iram_param.

Verification
REQ-025 Reset hold 3 cycles, then release -> BUSY=1 for 128 cycles; afterwards every ADDR reads Q=16'h0000.
REQ-026 LOAD_START pulse, then 42 beats with LD_DATA=index and LD_LAST on beat 41 -> LOAD_DONE pulse once, LD_COUNT=42, ADDR=8'h52 gives Q=16'h0029, ADDR=8'h54 gives Q=16'h0000.
REQ-027 LD_VALID toggled every other cycle during LOAD -> only valid cycles write; contents contiguous 0..N-1.
REQ-028 130 beats without LD_LAST -> LD_READY drops after beat 128, LD_COUNT=128, mem[0] not overwritten by beats 129-130.
REQ-029 RESET=0 at beat 10 of a load -> no LOAD_DONE, re-CLEAR runs, all entries read 16'h0000 after it.
REQ-030 ADDR=8'h05 with BUSY=0 -> ALIGN_ERR=1 and Q=mem[2]; LOAD_START during LOAD -> no effect.
